// File: rtl/mouse_pos_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | mouse_pos_decoder                                                        |
// | Assembles 3-byte PS/2 movement packets into clamped 12-bit cursor        |
// | coordinates plus left/right button state.                                |
// | Optional: MOUSE_MIDDLE_RECENTER_EN (middle-button press recentres).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mouse_pos_decoder #(
    parameter int X_MAX   = 799,
    parameter int Y_MAX   = 599,
    parameter int X_INIT  = 400,
    parameter int Y_INIT  = 300,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        pos_valid,
    output logic        sync_err
);

    localparam int                    c_timer_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_timer_w-1:0]  c_timer_last = c_timer_w'(TIMEOUT - 1);
    localparam logic [12:0]           c_x_max      = 13'(X_MAX);
    localparam logic [12:0]           c_y_max      = 13'(Y_MAX);
    localparam logic [11:0]           c_x_init     = 12'(X_INIT);
    localparam logic [11:0]           c_y_init     = 12'(Y_INIT);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_timer_w-1:0]   r_timer;
    logic [c_timer_w-1:0]   w_timer_nxt;
    logic                   w_timeout;
    logic                   w_b0_slot;
    logic                   w_b0_good;
    logic                   w_b0_bad;
    logic                   r_err_pend;
    logic [3:0]             r_hdr;      // {y_ovf, x_ovf, y_sign, x_sign}
    logic [1:0]             r_btn;      // {right, left}
    logic [7:0]             r_dx_lo;
    logic [7:0]             r_dy_lo;
    logic [8:0]             w_dx;
    logic [8:0]             w_dy;
    logic [12:0]            w_xs;
    logic [12:0]            w_ys;
    logic [11:0]            w_x_new;
    logic [11:0]            w_y_new;
    logic                   w_recenter;

    // UPDATE accepts a new header byte so back-to-back packets lose no bytes
    assign w_b0_slot = rx_valid && ((r_state == WAIT_B0) || (r_state == UPDATE));
    assign w_b0_good = w_b0_slot && rx_data[3];
    assign w_b0_bad  = w_b0_slot && !rx_data[3];

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        w_timeout   = 1'b0;
        unique case (r_state)
            WAIT_B0, UPDATE: w_state_nxt = w_b0_good ? WAIT_B1 : WAIT_B0;
            WAIT_B1, WAIT_B2: begin
                if (rx_valid) begin
                    w_state_nxt = (r_state == WAIT_B1) ? WAIT_B2 : UPDATE;
                end else if (r_timer == c_timer_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = WAIT_B0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_B0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr   <= '0;
            r_btn   <= '0;
            r_dx_lo <= '0;
            r_dy_lo <= '0;
        end else begin
            if (w_b0_good) begin
                r_hdr <= rx_data[7:4];
                r_btn <= rx_data[1:0];
            end
            if ((r_state == WAIT_B1) && rx_valid) r_dx_lo <= rx_data;
            if ((r_state == WAIT_B2) && rx_valid) r_dy_lo <= rx_data;
        end
    end

    // Overflowed axis contributes no motion
    assign w_dx = r_hdr[2] ? 9'd0 : {r_hdr[0], r_dx_lo};
    assign w_dy = r_hdr[3] ? 9'd0 : {r_hdr[1], r_dy_lo};
    assign w_xs = {1'b0, xpos} + {{4{w_dx[8]}}, w_dx};
    assign w_ys = {1'b0, ypos} - {{4{w_dy[8]}}, w_dy};

    always_comb begin
        w_x_new = w_xs[11:0];
        w_y_new = w_ys[11:0];
        if (w_xs[12])            w_x_new = '0;
        else if (w_xs > c_x_max) w_x_new = c_x_max[11:0];
        if (w_ys[12])            w_y_new = '0;
        else if (w_ys > c_y_max) w_y_new = c_y_max[11:0];
    end

`ifdef MOUSE_MIDDLE_RECENTER_EN
    logic r_mid;
    logic r_prev_m;

    assign w_recenter = r_mid && !r_prev_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mid    <= 1'b0;
            r_prev_m <= 1'b0;
        end else begin
            if (w_b0_good)           r_mid    <= rx_data[2];
            if (r_state == UPDATE)   r_prev_m <= r_mid;
        end
    end
`else
    assign w_recenter = 1'b0;
`endif

    // A bad header seen during UPDATE is reported one cycle late so it never
    // shares a cycle with pos_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos       <= c_x_init;
            ypos       <= c_y_init;
            left       <= 1'b0;
            right      <= 1'b0;
            pos_valid  <= 1'b0;
            sync_err   <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            pos_valid  <= (r_state == UPDATE);
            sync_err   <= w_timeout || r_err_pend || (w_b0_bad && (r_state == WAIT_B0));
            r_err_pend <= w_b0_bad && (r_state == UPDATE);
            if (r_state == UPDATE) begin
                xpos  <= w_recenter ? c_x_init : w_x_new;
                ypos  <= w_recenter ? c_y_init : w_y_new;
                left  <= r_btn[0];
                right <= r_btn[1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mouse_pos_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_mouse_pos_decoder                                                     |
// | Scoreboard bench: expected packets queued at stimulus, popped on         |
// | pos_valid. Revision: 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_mouse_pos_decoder;

    localparam int X_MAX   = 799;
    localparam int Y_MAX   = 599;
    localparam int X_INIT  = 400;
    localparam int Y_INIT  = 300;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        right;
    logic        pos_valid;
    logic        sync_err;

    int n_vec = 0;
    int n_err = 0;
    int pv_cnt = 0;
    int se_cnt = 0;
    int m_x = X_INIT;
    int m_y = Y_INIT;
    bit m_prev_m = 1'b0;
    logic [25:0] sb[$];

    always #5 clk = ~clk;

    mouse_pos_decoder #(
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX),
        .X_INIT (X_INIT),
        .Y_INIT (Y_INIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .xpos     (xpos),
        .ypos     (ypos),
        .left     (left),
        .right    (right),
        .pos_valid(pos_valid),
        .sync_err (sync_err)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [25:0] exp_v;
        if (sync_err) se_cnt++;
        if (pos_valid) begin
            pv_cnt++;
            n_vec++;
            if (sync_err !== 1'b0) begin
                n_err++;
                $display("FAIL overlap: sync_err=%b with pos_valid, required 0", sync_err);
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pkt: unexpected pos_valid x=%0d y=%0d, required none", xpos, ypos);
            end else begin
                exp_v = sb.pop_front();
                if ({xpos, ypos, left, right} !== exp_v) begin
                    n_err++;
                    $display("FAIL pkt: got x=%0d y=%0d l=%b r=%b, required x=%0d y=%0d l=%b r=%b",
                             xpos, ypos, left, right, exp_v[25:14], exp_v[13:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    function automatic int clampi(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx;
        int dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
`ifdef MOUSE_MIDDLE_RECENTER_EN
        if (b0[2] && !m_prev_m) begin
            m_x = X_INIT;
            m_y = Y_INIT;
        end else begin
            m_x = clampi(m_x + dx, X_MAX);
            m_y = clampi(m_y - dy, Y_MAX);
        end
        m_prev_m = b0[2];
`else
        m_x = clampi(m_x + dx, X_MAX);
        m_y = clampi(m_y - dy, Y_MAX);
`endif
        sb.push_back({12'(m_x), 12'(m_y), b0[0], b0[1]});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int gap);
        model_packet(b0, b1, b2);
        send_byte(b0);
        idle(gap);
        send_byte(b1);
        idle(gap);
        send_byte(b2);
    endtask

    task automatic check_drained(input string name);
        idle(4);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: %0d packets outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_vec += 3;
        if ({xpos, ypos} !== {12'd400, 12'd300}) begin
            n_err++;
            $display("FAIL reset_pos: got %0d/%0d, required 400/300", xpos, ypos);
        end
        if ({left, right} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_btn: got %b%b, required 00", left, right);
        end
        if ({pos_valid, sync_err} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_pulse: got pv=%b se=%b, required 0 0", pos_valid, sync_err);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_latency();
        model_packet(8'h08, 8'h0A, 8'h05);
        send_byte(8'h08);
        send_byte(8'h0A);
        send_byte(8'h05);
        n_vec += 3;
        if (pos_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_early: pos_valid=%b one edge after byte2, required 0", pos_valid);
        end
        idle(1);
        if ({pos_valid, xpos, ypos, left} !== {1'b1, 12'd410, 12'd295, 1'b0}) begin
            n_err++;
            $display("FAIL lat_update: got pv=%b x=%0d y=%0d l=%b, required 1 410 295 0",
                     pos_valid, xpos, ypos, left);
        end
        idle(1);
        if (pos_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_width: pos_valid=%b second cycle, required 0", pos_valid);
        end
        check_drained("latency");
    endtask

    task automatic test_clamp();
        send_packet(8'h18, 8'h00, 8'h00, 1);
        send_packet(8'h18, 8'h00, 8'h00, 1);
        send_packet(8'h08, 8'h7F, 8'h80, 1);
        send_packet(8'h28, 8'h00, 8'h00, 2);
        send_packet(8'h28, 8'h00, 8'h00, 2);
        for (int i = 0; i < 6; i++) send_packet(8'h08, 8'h7F, 8'h00, 0);
        check_drained("clamp");
        n_vec++;
        if ({xpos, ypos} !== {12'd799, 12'd599}) begin
            n_err++;
            $display("FAIL clamp_max: got %0d/%0d, required 799/599", xpos, ypos);
        end
    endtask

    task automatic test_bad_byte0();
        int se0;
        int pv0;
        se0 = se_cnt;
        pv0 = pv_cnt;
        send_byte(8'h00);
        idle(4);
        n_vec++;
        if ((se_cnt - se0) != 1 || pv_cnt != pv0) begin
            n_err++;
            $display("FAIL bad_b0: sync_err pulses=%0d pos_valid=%0d, required 1 0",
                     se_cnt - se0, pv_cnt - pv0);
        end
        send_packet(8'h09, 8'h01, 8'h00, 1);
        check_drained("bad_b0");
    endtask

    task automatic test_timeout();
        int se0;
        int first;
        se0   = se_cnt;
        first = 0;
        send_byte(8'h09);
        send_byte(8'h01);
        for (int i = 1; i <= TIMEOUT + 2; i++) begin
            idle(1);
            if (sync_err && first == 0) first = i;
        end
        n_vec += 3;
        if (first != TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_cycle: sync_err after %0d idle cycles, required %0d", first, TIMEOUT);
        end
        if ((se_cnt - se0) != 1) begin
            n_err++;
            $display("FAIL timeout_pulses: got %0d, required 1", se_cnt - se0);
        end
        if ({xpos, ypos} !== {12'(m_x), 12'(m_y)}) begin
            n_err++;
            $display("FAIL timeout_hold: got %0d/%0d, required %0d/%0d", xpos, ypos, m_x, m_y);
        end
        se0 = se_cnt;
        send_packet(8'h0A, 8'h10, 8'hF0, TIMEOUT - 1);
        send_packet(8'h38, 8'hF6, 8'hFB, 0);
        check_drained("timeout");
        n_vec++;
        if (se_cnt != se0) begin
            n_err++;
            $display("FAIL timeout_edge: %0d sync_err at gap TIMEOUT-1, required 0", se_cnt - se0);
        end
    endtask

    task automatic test_overflow();
        send_packet(8'h48, 8'hFF, 8'h02, 1);
        send_packet(8'h88, 8'h05, 8'h80, 1);
`ifdef MOUSE_MIDDLE_RECENTER_EN
        send_packet(8'h0C, 8'h10, 8'h10, 1);
        check_drained("recenter");
        n_vec++;
        if ({xpos, ypos} !== {12'd400, 12'd300}) begin
            n_err++;
            $display("FAIL recenter: got %0d/%0d, required 400/300", xpos, ypos);
        end
        send_packet(8'h0C, 8'h10, 8'h10, 1);
`endif
        check_drained("overflow");
    endtask

    task automatic test_back_to_back();
        int se0;
        send_packet(8'h08, 8'h03, 8'h02, 0);
        send_packet(8'h19, 8'hFE, 8'h01, 0);
        send_packet(8'h2A, 8'h04, 8'hFC, 0);
        se0 = se_cnt;
        send_packet(8'h09, 8'h02, 8'h03, 0);
        send_byte(8'h00);
        idle(3);
        n_vec++;
        if ((se_cnt - se0) != 1) begin
            n_err++;
            $display("FAIL b2b_bad_b0: sync_err pulses=%0d, required 1", se_cnt - se0);
        end
        send_packet(8'h08, 8'h01, 8'h01, 0);
        check_drained("b2b");
    endtask

    task automatic test_random();
        logic [7:0] b0;
        for (int i = 0; i < 24; i++) begin
            b0 = 8'(($urandom & 32'hF7) | 32'h08);
            send_packet(b0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end
        check_drained("random");
    endtask

    task automatic test_midreset();
        send_packet(8'h08, 8'h20, 8'h20, 0);
        check_drained("pre_reset");
        send_byte(8'h09);
        send_byte(8'h05);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({xpos, ypos, left} !== {12'd400, 12'd300, 1'b0}) begin
            n_err++;
            $display("FAIL midreset: got %0d/%0d l=%b, required 400/300 l=0", xpos, ypos, left);
        end
        m_x      = X_INIT;
        m_y      = Y_INIT;
        m_prev_m = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_packet(8'h08, 8'h03, 8'h04, 1);
        check_drained("midreset");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_clamp();
        test_bad_byte0();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
